// File: rtl/seq_binary_to_bcd_pkg.sv
// Shared constants for the sequential binary-to-BCD converter and its downstream
// display path (bcd_to_ascii, scroller).
package seq_binary_to_bcd_pkg;

  localparam int unsigned DEFAULT_BIN_BITS   = 40;
  localparam int unsigned DEFAULT_NUM_DIGITS = 10;

  function automatic int unsigned bcdBits(input int unsigned numDigits);
    return numDigits * 4;
  endfunction

  localparam int unsigned DEFAULT_BCD_BITS = bcdBits(DEFAULT_NUM_DIGITS);

  // Largest value that fits in the display: 10^numDigits - 1.
  function automatic logic [63:0] maxDisplayable(input int unsigned numDigits);
    logic [63:0] p;
    p = 64'd1;
    for (int unsigned i = 0; i < numDigits; i++) p = p * 64'd10;
    return p - 64'd1;
  endfunction

  localparam logic [39:0] MAX_DISPLAYABLE = 40'd9_999_999_999;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

endpackage

// File: rtl/seq_binary_to_bcd_if.sv
// Request/result bundle between a binary source and the BCD converter.
interface seq_binary_to_bcd_if #(
  parameter int unsigned BIN_BITS   = 40,
  parameter int unsigned NUM_DIGITS = 10
);
  localparam int unsigned BCD_BITS = NUM_DIGITS * 4;

  logic [BIN_BITS-1:0] bin;
  logic                start;
  logic                busy;
  logic                done;
  logic [BCD_BITS-1:0] bcd;
  logic                overflow;

  modport master (output bin, start, input busy, done, bcd, overflow);
  modport slave  (input bin, start, output busy, done, bcd, overflow);
endinterface

// File: rtl/seq_binary_to_bcd_adjust.sv
// Double-dabble correction cell: adds 3 to a BCD digit that is 5 or more.
module bcd_digit_adjust (
  input  logic [3:0] digit,
  output logic [3:0] adjusted
);
  always_comb begin
    adjusted = digit;
    if (digit >= 4'd5) adjusted = digit + 4'd3;
  end
endmodule

// File: rtl/seq_binary_to_bcd.sv
// Multi-cycle double-dabble binary to packed BCD converter, one shift-and-adjust
// step per clock; saturates to all nines and flags overflow above the display range.
module seq_binary_to_bcd
  import seq_binary_to_bcd_pkg::*;
#(
  parameter int unsigned BIN_BITS   = DEFAULT_BIN_BITS,
  parameter int unsigned NUM_DIGITS = DEFAULT_NUM_DIGITS,
  parameter int unsigned BCD_BITS   = bcdBits(NUM_DIGITS)
) (
  input logic clk,
  input logic reset,
  seq_binary_to_bcd_if.slave conv
);

  localparam int unsigned       CNT_BITS  = $clog2(BIN_BITS);
  localparam logic [BIN_BITS-1:0] MAX_VALUE = BIN_BITS'(maxDisplayable(NUM_DIGITS));
  localparam logic [CNT_BITS-1:0] LAST_STEP = CNT_BITS'(BIN_BITS - 1);

  state_t              state, stateNext;
  logic [BIN_BITS-1:0] shiftReg, shiftNext;
  logic [BCD_BITS-1:0] work, workNext, adjusted, stepped;
  logic [BCD_BITS-1:0] bcdReg, bcdNext;
  logic [CNT_BITS-1:0] count, countNext;
  logic                pending, pendingNext;
  logic                ovReg, ovNext;
  logic                doneReg, doneNext;

  for (genvar d = 0; d < NUM_DIGITS; d++) begin : g_adjust
    bcd_digit_adjust u_adjust (
      .digit    (work[d*4 +: 4]),
      .adjusted (adjusted[d*4 +: 4])
    );
  end

  assign stepped = {adjusted[BCD_BITS-2:0], shiftReg[BIN_BITS-1]};

  always_comb begin
    stateNext   = state;
    shiftNext   = shiftReg;
    workNext    = work;
    countNext   = count;
    pendingNext = pending;
    bcdNext     = bcdReg;
    ovNext      = ovReg;
    doneNext    = 1'b0;
    case (state)
      IDLE: begin
        if (conv.start) begin
          shiftNext   = conv.bin;
          workNext    = '0;
          countNext   = '0;
          pendingNext = (conv.bin > MAX_VALUE);
          stateNext   = SHIFT;
        end
      end
      SHIFT: begin
        workNext  = stepped;
        shiftNext = shiftReg << 1;
        countNext = count + 1'b1;
        if (count == LAST_STEP) begin
          bcdNext   = pending ? {NUM_DIGITS{4'h9}} : stepped;
          ovNext    = pending;
          doneNext  = 1'b1;
          stateNext = IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      shiftReg <= '0;
      work     <= '0;
      count    <= '0;
      pending  <= 1'b0;
      bcdReg   <= '0;
      ovReg    <= 1'b0;
      doneReg  <= 1'b0;
    end else begin
      state    <= stateNext;
      shiftReg <= shiftNext;
      work     <= workNext;
      count    <= countNext;
      pending  <= pendingNext;
      bcdReg   <= bcdNext;
      ovReg    <= ovNext;
      doneReg  <= doneNext;
    end
  end

  assign conv.busy     = (state == SHIFT);
  assign conv.done     = doneReg;
  assign conv.bcd      = bcdReg;
  assign conv.overflow = ovReg;

endmodule

// File: tb/tb_seq_binary_to_bcd.sv
// Scoreboard bench for seq_binary_to_bcd: directed conversions, latency,
// ignored restarts, back-to-back starts and mid-conversion reset.
module tb_seq_binary_to_bcd;

  typedef struct {
    logic [39:0] bcd;
    logic        ov;
    int          doneCycle;
  } expect_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  expect_t sb[$];

  seq_binary_to_bcd_if #(.BIN_BITS(40), .NUM_DIGITS(10)) conv ();

  seq_binary_to_bcd #(.BIN_BITS(40), .NUM_DIGITS(10)) dut (
    .clk   (clk),
    .reset (reset),
    .conv  (conv.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (reset && conv.done === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 expected none (cycle %0d)", cyc);
      end else begin
        expect_t e;
        e = sb.pop_front();
        check("bcd", 64'(conv.bcd), 64'(e.bcd));
        check("overflow", 64'(conv.overflow), 64'(e.ov));
        check("latency", 64'(cyc), 64'(e.doneCycle));
        check("busy_at_done", 64'(conv.busy), 64'd0);
      end
    end
  end

  task automatic issue(input logic [39:0] b, input logic [39:0] expBcd, input logic expOv);
    @(negedge clk);
    conv.bin   = b;
    conv.start = 1'b1;
    sb.push_back('{expBcd, expOv, cyc + 41});
    @(negedge clk);
    conv.start = 1'b0;
    check("busy_after_start", 64'(conv.busy), 64'd1);
  endtask

  task automatic waitIdle();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL timeout: got %0d pending results expected 0", sb.size());
      sb.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    conv.bin   = '0;
    conv.start = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_busy", 64'(conv.busy), 64'd0);
    check("reset_done", 64'(conv.done), 64'd0);
    check("reset_bcd", 64'(conv.bcd), 64'd0);
    check("reset_overflow", 64'(conv.overflow), 64'd0);
    reset = 1'b1;

    issue(40'd0,              40'h0000000000, 1'b0); waitIdle();
    issue(40'd9999,           40'h0000009999, 1'b0); waitIdle();
    issue(40'd1234567890,     40'h1234567890, 1'b0); waitIdle();
    issue(40'd9_999_999_999,  40'h9999999999, 1'b0); waitIdle();
    issue(40'd10_000_000_000, 40'h9999999999, 1'b1); waitIdle();
    issue(40'd42,             40'h0000000042, 1'b0); waitIdle();
    issue(40'd8_765_432_109,  40'h8765432109, 1'b0); waitIdle();

    // Restart while busy must be ignored and bin changes must not leak in.
    issue(40'd5, 40'h0000000005, 1'b0);
    repeat (9) @(negedge clk);
    conv.bin   = 40'd7;
    conv.start = 1'b1;
    @(negedge clk);
    conv.start = 1'b0;
    waitIdle();

    // Start held high through done: two conversions exactly 41 cycles apart.
    @(negedge clk);
    conv.bin   = 40'd3;
    conv.start = 1'b1;
    sb.push_back('{40'h0000000003, 1'b0, cyc + 41});
    sb.push_back('{40'h0000000003, 1'b0, cyc + 82});
    repeat (42) @(negedge clk);
    conv.start = 1'b0;
    waitIdle();

    // Reset mid-conversion aborts with no done.
    issue(40'd77, 40'h0000000077, 1'b0); waitIdle();
    @(negedge clk);
    conv.bin   = 40'd2000;
    conv.start = 1'b1;
    @(negedge clk);
    conv.start = 1'b0;
    repeat (18) @(negedge clk);
    reset = 1'b0;
    #1;
    check("abort_bcd", 64'(conv.bcd), 64'd0);
    check("abort_busy", 64'(conv.busy), 64'd0);
    check("abort_overflow", 64'(conv.overflow), 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (50) @(negedge clk);
    issue(40'd2000, 40'h0000002000, 1'b0); waitIdle();

    repeat (5) @(negedge clk);
    check("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
